// File: rtl/vga_dac_driver.sv
// vga_dac_driver: VGA timing generator and test-pattern source for current-steering RGB DACs.
// Latency: every output is registered, one pixel clock after the counters hold (h,v).
// Backpressure: none; free-running pixel stream paced only by clk.
//
// Ports:
//   clk, rst_n              pixel clock, asynchronous active-low reset
//   mode[1:0]               pattern select (0 solid, 1 gradient, 2 XOR, 3 animated), taken at frame start
//   colour[3*DAC_BITS-1:0]  solid colour {R,G,B} for mode 0
//   hsync, vsync            sync pulses, asserted level = SYNC_POL
//   hblank, vblank          active-high blanking flags
//   r, g, b / rn, gn, bn    binary DAC codes and their exact complements
//   bthermo                 per-group thermometer lines for the segmented blue DAC, group 0 in LSBs
module vga_dac_driver #(
  parameter int DAC_BITS = 8,
  parameter int SEG_BITS = 2,
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter bit SYNC_POL = 1'b0
) (
  input  logic                                        clk,
  input  logic                                        rst_n,
  input  logic [1:0]                                  mode,
  input  logic [3*DAC_BITS-1:0]                       colour,
  output logic                                        hsync,
  output logic                                        vsync,
  output logic                                        hblank,
  output logic                                        vblank,
  output logic [DAC_BITS-1:0]                         r,
  output logic [DAC_BITS-1:0]                         g,
  output logic [DAC_BITS-1:0]                         b,
  output logic [DAC_BITS-1:0]                         rn,
  output logic [DAC_BITS-1:0]                         gn,
  output logic [DAC_BITS-1:0]                         bn,
  output logic [(DAC_BITS/SEG_BITS)*((1<<SEG_BITS)-1)-1:0] bthermo
);

  localparam int NSEG    = DAC_BITS / SEG_BITS;
  localparam int NLINE   = (1 << SEG_BITS) - 1;
  localparam int TW      = NSEG * NLINE;
  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  // One spare count of headroom so the sync-end boundary never aliases to 0.
  localparam int HW      = $clog2(H_TOTAL + 1);
  localparam int VW      = $clog2(V_TOTAL + 1);

  localparam logic [HW-1:0] H_LAST = HW'(H_TOTAL - 1);
  localparam logic [HW-1:0] H_ACT  = HW'(H_ACTIVE);
  localparam logic [HW-1:0] H_SS   = HW'(H_ACTIVE + H_FP);
  localparam logic [HW-1:0] H_SE   = HW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [VW-1:0] V_LAST = VW'(V_TOTAL - 1);
  localparam logic [VW-1:0] V_ACT  = VW'(V_ACTIVE);
  localparam logic [VW-1:0] V_SS   = VW'(V_ACTIVE + V_FP);
  localparam logic [VW-1:0] V_SE   = VW'(V_ACTIVE + V_FP + V_SYNC);

  logic [HW-1:0] h;
  logic [VW-1:0] v;
  logic [7:0]    frame;
  logic [1:0]    mode_sh;

  logic h_last, v_last, frame_start;
  assign h_last      = (h == H_LAST);
  assign v_last      = (v == V_LAST);
  assign frame_start = (h == '0) && (v == '0);

  // Position counters, frame counter and the per-frame mode shadow.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      h       <= '0;
      v       <= '0;
      frame   <= '0;
      mode_sh <= '0;
    end else begin
      h <= h_last ? '0 : h + HW'(1);
      if (h_last) begin
        v <= v_last ? '0 : v + VW'(1);
      end
      if (h_last && v_last) begin
        frame <= frame + 8'd1;
      end
      if (frame_start) begin
        mode_sh <= mode;
      end
    end
  end

  // The first pixel of a frame must already use the freshly sampled mode,
  // so bypass the shadow while it is being loaded.
  logic [1:0] mode_eff;
  assign mode_eff = frame_start ? mode : mode_sh;

  logic hb_n, vb_n, hs_n, vs_n;
  assign hb_n = (h >= H_ACT);
  assign vb_n = (v >= V_ACT);
  assign hs_n = ((h >= H_SS) && (h < H_SE)) ? SYNC_POL : ~SYNC_POL;
  assign vs_n = ((v >= V_SS) && (v < V_SE)) ? SYNC_POL : ~SYNC_POL;

  // Pattern arithmetic is done at DAC width so every result wraps modulo 2^DAC_BITS.
  logic [DAC_BITS-1:0] hc, vc, fc, xc;
  assign hc = DAC_BITS'(h);
  assign vc = DAC_BITS'(v);
  assign fc = DAC_BITS'(frame);
  assign xc = hc ^ vc;

  logic [DAC_BITS-1:0] r_n, g_n, b_n;
  always_comb begin
    r_n = '0;
    g_n = '0;
    b_n = '0;
    case (mode_eff)
      2'd0: {r_n, g_n, b_n} = colour;
      2'd1: begin
        r_n = hc;
        g_n = vc;
        b_n = hc + vc;
      end
      2'd2: begin
        r_n = xc;
        g_n = xc;
        b_n = xc;
      end
      default: begin
        r_n = hc + fc;
        g_n = vc + fc;
        b_n = xc + fc;
      end
    endcase
    if (hb_n || vb_n) begin
      r_n = '0;
      g_n = '0;
      b_n = '0;
    end
  end

  // Thermometer decode is taken from the already-blanked blue code so it
  // stays aligned with b and collapses to zero during blanking.
  logic [TW-1:0] therm_n;
  for (genvar k = 0; k < NSEG; k++) begin : g_seg
    for (genvar j = 1; j <= NLINE; j++) begin : g_line
      assign therm_n[k*NLINE + j - 1] = (b_n[k*SEG_BITS +: SEG_BITS] >= SEG_BITS'(j));
    end
  end

  // Single output register stage: all outputs launch from the same edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hsync   <= ~SYNC_POL;
      vsync   <= ~SYNC_POL;
      hblank  <= 1'b1;
      vblank  <= 1'b1;
      r       <= '0;
      g       <= '0;
      b       <= '0;
      rn      <= '1;
      gn      <= '1;
      bn      <= '1;
      bthermo <= '0;
    end else begin
      hsync   <= hs_n;
      vsync   <= vs_n;
      hblank  <= hb_n;
      vblank  <= vb_n;
      r       <= r_n;
      g       <= g_n;
      b       <= b_n;
      rn      <= ~r_n;
      gn      <= ~g_n;
      bn      <= ~b_n;
      bthermo <= therm_n;
    end
  end

endmodule
